tbec_encode_pipe: RTL and testbench



---
 rtl/tbec_encode_pipe.sv | 135 +++++++++++++
 tb/tb_tbec_encode_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tbec_encode_pipe.sv
// tbec_encode_pipe: two-stage valid/ready TBEC encoder.
// It turns 16-bit data words into 32-bit codewords laid out for the TBEC decoder.
// It also keeps a wrapping count of codewords accepted downstream.
// Optional feature macro: TBEC_ERR_INJECT_EN. It adds one-shot XOR error injection
// on the next codeword loaded into the output stage.

// Combinational codeword generator.
// Data bits are grouped as A/B/C/D rows of four bits each.
module tbec_enc_core (
  input  logic [15:0] d,
  output logic [31:0] cw
);
  logic [4:1] a, b, c, e;
  logic [3:0] di, p;
  logic [7:0] xc;

  // Split the word into rows, form the diagonals, parities and checks, then pack them.
  always_comb begin
    a = {d[3],  d[7],  d[11], d[15]};
    b = {d[2],  d[6],  d[10], d[14]};
    c = {d[1],  d[5],  d[9],  d[13]};
    e = {d[0],  d[4],  d[8],  d[12]};
    // Packed as {DI1,DI4,DI2,DI3}.
    di = {a[1] ^ b[2] ^ c[1] ^ e[2],
          a[4] ^ b[3] ^ c[4] ^ e[3],
          a[2] ^ b[1] ^ c[2] ^ e[1],
          a[3] ^ b[4] ^ c[3] ^ e[4]};
    // Packed as {P1,P4,P2,P3}.
    p  = {a[1] ^ a[2] ^ b[1] ^ b[2],
          c[3] ^ c[4] ^ e[3] ^ e[4],
          c[1] ^ c[2] ^ e[1] ^ e[2],
          a[3] ^ a[4] ^ b[3] ^ b[4]};
    xc = {a[1] ^ a[3], a[2] ^ a[4],
          b[1] ^ b[3], b[2] ^ b[4],
          c[1] ^ c[3], c[2] ^ c[4],
          e[1] ^ e[3], e[2] ^ e[4]};
    cw = {d, di, p, xc};
  end
endmodule

module tbec_encode_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [CNT_W-1:0] word_count,
`ifdef TBEC_ERR_INJECT_EN
  input  logic             inj_arm,
  input  logic [31:0]      inj_mask,
  output logic             inj_pending,
`endif
  output logic             busy
);
  logic        s1_valid;
  logic [15:0] s1_data;
  logic        s1_adv;
  logic        s2_load;
  logic [31:0] enc_cw;
  logic [31:0] load_cw;

  tbec_enc_core u_enc (.d(s1_data), .cw(enc_cw));

  // S1 may hand its word on whenever S2 is empty or is draining this cycle.
  always_comb begin
    s1_adv   = ~out_valid | out_ready;
    in_ready = ~s1_valid | s1_adv;
    s2_load  = s1_valid & s1_adv;
    busy     = s1_valid | out_valid;
  end

`ifdef TBEC_ERR_INJECT_EN
  logic [31:0] inj_mask_q;

  // An arm in the same cycle as a load takes effect on that load.
  always_comb begin
    load_cw = enc_cw;
    if (inj_arm)          load_cw = enc_cw ^ inj_mask;
    else if (inj_pending) load_cw = enc_cw ^ inj_mask_q;
  end

  // Arm latches the mask. The next S2 load consumes it as a one-shot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pending <= 1'b0;
      inj_mask_q  <= '0;
    end else if (s2_load) begin
      inj_pending <= 1'b0;
    end else if (inj_arm) begin
      inj_pending <= 1'b1;
      inj_mask_q  <= inj_mask;
    end
  end
`else
  // The codeword passes through unmodified.
  always_comb load_cw = enc_cw;
`endif

  // Input register: take a new word on handshake, otherwise empty out when advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register: hold under backpressure, refill from S1, or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_word  <= load_cw;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count accepted codewords. The count wraps and does not saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       word_count <= '0;
    else if (out_valid && out_ready)  word_count <= word_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_tbec_encode_pipe.sv
// Directed bench for tbec_encode_pipe.
// A second instance with CNT_W=4 shares the same stimulus to exercise counter wrap.
module tb_tbec_encode_pipe;
  logic        clk, rst_n;
  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_word;
  logic [15:0] word_count;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_word4;
  logic [3:0]  word_count4;
`ifdef TBEC_ERR_INJECT_EN
  logic        inj_arm;
  logic [31:0] inj_mask;
  logic        inj_pending, inj_pending4;
`endif

  int checks = 0;
  int errors = 0;

  tbec_encode_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .word_count(word_count),
`ifdef TBEC_ERR_INJECT_EN
    .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_pending(inj_pending),
`endif
    .busy(busy));

  tbec_encode_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_word(out_word4), .word_count(word_count4),
`ifdef TBEC_ERR_INJECT_EN
    .inj_arm(inj_arm), .inj_mask(inj_mask), .inj_pending(inj_pending4),
`endif
    .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference codeword, written straight from the row/diagonal equations.
  function automatic logic [31:0] model(input logic [15:0] d);
    logic [4:1] a, b, c, e;
    logic di1, di2, di3, di4, p1, p2, p3, p4;
    for (int k = 1; k <= 4; k++) begin
      a[k] = d[19-4*k]; b[k] = d[18-4*k]; c[k] = d[17-4*k]; e[k] = d[16-4*k];
    end
    di1 = a[1]^b[2]^c[1]^e[2]; di2 = a[2]^b[1]^c[2]^e[1];
    di3 = a[3]^b[4]^c[3]^e[4]; di4 = a[4]^b[3]^c[4]^e[3];
    p1 = a[1]^a[2]^b[1]^b[2];  p2 = c[1]^c[2]^e[1]^e[2];
    p3 = a[3]^a[4]^b[3]^b[4];  p4 = c[3]^c[4]^e[3]^e[4];
    return {d, di1, di4, di2, di3, p1, p4, p2, p3,
            a[1]^a[3], a[2]^a[4], b[1]^b[3], b[2]^b[4],
            c[1]^c[3], c[2]^c[4], e[1]^e[3], e[2]^e[4]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    #3 rst_n = 1'b1;
    tick();
  endtask

  logic [15:0] vec_in  [4];
  logic [31:0] vec_out [4];
  logic [15:0] words   [100];
  logic [15:0] bp      [2];
  int          acc, got;
  logic        hs;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef TBEC_ERR_INJECT_EN
    inj_arm = 1'b0; inj_mask = '0;
`endif
    #12 rst_n = 1'b1;
    tick();
    check("init_in_ready", 64'(in_ready), 64'd1);
    check("init_out_word", 64'(out_word), 64'd0);

    // Mid-stream reset: in-flight words are discarded and never appear.
    in_valid = 1'b1; in_data = 16'h1234; tick();
    in_data = 16'h5678; tick();
    in_valid = 1'b0;
    do_reset();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    check("post_rst_no_output", 64'(out_valid), 64'd0);
    check("post_rst_word", 64'(out_word), 64'd0);

    // Single words with hand-computed codewords; each appears exactly once.
    vec_in  = '{16'h0000, 16'h8000, 16'h0001, 16'hFFFF};
    vec_out = '{32'h00000000, 32'h80008880, 32'h00011401, 32'hFFFF0000};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec_in[i];
      check("single_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("single_lat1_valid", 64'(out_valid), 64'd0);
      tick();
      check("single_lat2_valid", 64'(out_valid), 64'd1);
      check("single_word", 64'(out_word), 64'(vec_out[i]));
      tick();
      check("single_once", 64'(out_valid), 64'd0);
    end
    check("single_count", 64'(word_count), 64'd4);

    // 100-word stream at full rate.
    do_reset();
    for (int i = 0; i < 100; i++) words[i] = 16'($urandom);
    for (int c = 0; c <= 100; c++) begin
      in_valid = (c < 100);
      in_data  = (c < 100) ? words[c] : 16'h0;
      tick();
      if (c >= 1) begin
        check("stream_valid", 64'(out_valid), 64'd1);
        check("stream_word", 64'(out_word), 64'(model(words[c-1])));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_count", 64'(word_count), 64'd100);
    check("stream_count4", 64'(word_count4), 64'(100 % 16));
    tick();
    check("stream_idle_busy", 64'(busy), 64'd0);

    // Backpressure: five stalled cycles admit exactly two words.
    do_reset();
    bp = '{16'hA5C3, 16'h0F0F};
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = (acc < 2) ? bp[acc] : 16'hDEAD;
      hs = in_valid & in_ready;
      tick();
      if (hs) acc++;
      if (c >= 2) check("bp_stable", 64'(out_word), 64'(model(bp[0])));
    end
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_busy", 64'(busy), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1; got = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid && out_ready) begin
        check("bp_drain_word", 64'(out_word), 64'(model(bp[got < 2 ? got : 1])));
        got++;
      end
      tick();
    end
    check("bp_drained", 64'(got), 64'd2);
    check("bp_count", 64'(word_count), 64'd2);

    // Counter wrap: 17 transfers leave the 4-bit counter at 1.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      in_valid = 1'b1; in_data = 16'(c * 16'h0123); tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("wrap_count16", 64'(word_count), 64'd17);
    check("wrap_count4", 64'(word_count4), 64'd1);

`ifdef TBEC_ERR_INJECT_EN
    // One-shot injection hits only the next loaded codeword.
    do_reset();
    inj_arm = 1'b1; inj_mask = 32'h80000000; tick();
    inj_arm = 1'b0; inj_mask = 32'h0;
    check("inj_pending_set", 64'(inj_pending), 64'd1);
    in_valid = 1'b1; in_data = 16'h0000; tick();
    in_data = 16'h0001; tick();
    in_valid = 1'b0;
    check("inj_word", 64'(out_word), 64'h80000000);
    check("inj_pending_clr", 64'(inj_pending), 64'd0);
    tick();
    check("inj_next_clean", 64'(out_word), 64'h00011401);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
